// File: rtl/alu_muldiv_pkg.sv
// rtl/alu_muldiv_pkg.sv - shared types and encodings for the RV32M multiply/divide controller
package alu_muldiv_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DIV  = 2'd2,
        DONE = 2'd3
    } state_t;

    localparam logic [2:0] F3_MUL    = 3'b000;
    localparam logic [2:0] F3_MULH   = 3'b001;
    localparam logic [2:0] F3_MULHSU = 3'b010;
    localparam logic [2:0] F3_MULHU  = 3'b011;
    localparam logic [2:0] F3_DIV    = 3'b100;
    localparam logic [2:0] F3_DIVU   = 3'b101;
    localparam logic [2:0] F3_REM    = 3'b110;
    localparam logic [2:0] F3_REMU   = 3'b111;

    localparam logic [1:0] ALUOP_RTYPE = 2'b10;
    localparam logic [6:0] F7_MULDIV   = 7'b0000001;

endpackage

// File: rtl/alu_muldiv_if.sv
// rtl/alu_muldiv_if.sv - request/response handshake bundle between the EX stage and the mul/div unit
interface alu_muldiv_if #(parameter int XLEN = 32);
    logic            flush;
    logic            in_valid;
    logic            in_ready;
    logic [1:0]      ALUOp;
    logic [6:0]      Funct7;
    logic [2:0]      Funct3;
    logic [XLEN-1:0] src_a;
    logic [XLEN-1:0] src_b;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] result;
    logic            illegal;
    logic            busy;

    modport master (
        output flush, in_valid, ALUOp, Funct7, Funct3, src_a, src_b, out_ready,
        input  in_ready, out_valid, result, illegal, busy
    );

    modport slave (
        input  flush, in_valid, ALUOp, Funct7, Funct3, src_a, src_b, out_ready,
        output in_ready, out_valid, result, illegal, busy
    );
endinterface

// File: rtl/muldiv_datapath.sv
// rtl/muldiv_datapath.sv - shared shift-add / restoring-divide accumulator with final sign correction
module muldiv_datapath #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            load,
    input  logic            step,
    input  logic            is_div,
    input  logic            neg,
    input  logic            sel_hi,
    input  logic [XLEN-1:0] a_mag,
    input  logic [XLEN-1:0] b_mag,
    output logic [XLEN-1:0] res
);
    // acc holds {hi, lo}: for multiply {partial product, remaining multiplier},
    // for divide {partial remainder, dividend bits shifting into quotient}.
    logic [2*XLEN-1:0] acc_q, acc_d, acc_step, prod_fix;
    logic [XLEN-1:0]   opnd_q, opnd_d, half;
    logic              is_div_q, is_div_d, neg_q, neg_d, hi_q, hi_d;
    logic [XLEN:0]     mul_sum, part_rem, diff;

    always_comb begin
        mul_sum  = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
        part_rem = {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-1]};
        diff     = part_rem - {1'b0, opnd_q};
        if (is_div_q) begin
            acc_step = diff[XLEN] ? {part_rem[XLEN-1:0], acc_q[XLEN-2:0], 1'b0}
                                  : {diff[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};
        end else begin
            acc_step = {mul_sum, acc_q[XLEN-1:1]};
        end
        // Products are negated as a whole; quotient and remainder each on their own.
        prod_fix = neg_q ? -acc_step : acc_step;
        half     = hi_q ? acc_step[2*XLEN-1:XLEN] : acc_step[XLEN-1:0];
        if (is_div_q) res = neg_q ? -half : half;
        else          res = hi_q ? prod_fix[2*XLEN-1:XLEN] : prod_fix[XLEN-1:0];

        acc_d    = acc_q;
        opnd_d   = opnd_q;
        is_div_d = is_div_q;
        neg_d    = neg_q;
        hi_d     = hi_q;
        if (load) begin
            acc_d    = {{XLEN{1'b0}}, a_mag};
            opnd_d   = b_mag;
            is_div_d = is_div;
            neg_d    = neg;
            hi_d     = sel_hi;
        end else if (step) begin
            acc_d = acc_step;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            acc_q    <= '0;
            opnd_q   <= '0;
            is_div_q <= 1'b0;
            neg_q    <= 1'b0;
            hi_q     <= 1'b0;
        end else begin
            acc_q    <= acc_d;
            opnd_q   <= opnd_d;
            is_div_q <= is_div_d;
            neg_q    <= neg_d;
            hi_q     <= hi_d;
        end
    end
endmodule

// File: rtl/alu_muldiv_controller.sv
// rtl/alu_muldiv_controller.sv - RV32M decode, sequencing FSM, iteration counter and handshake
module alu_muldiv_controller #(
    parameter int XLEN = 32
) (
    input  logic         clk,
    input  logic         reset,
    alu_muldiv_if.slave  bus
);
    import alu_muldiv_pkg::*;

    localparam int              CNT_W    = $clog2(XLEN);
    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(XLEN - 1);
    localparam logic [XLEN-1:0]  MIN_VAL  = {1'b1, {(XLEN-1){1'b0}}};

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [XLEN-1:0]   result_q, result_d;
    logic              illegal_q, illegal_d;

    logic [2:0]        f3;
    logic              is_mop, is_div_op, is_rem, a_signed, b_signed, a_neg, b_neg;
    logic              div_zero, div_ovf, sel_hi, neg_res, dp_load, dp_step;
    logic [XLEN-1:0]   a_mag, b_mag, special_res, dp_res;

    always_comb begin
        f3        = bus.Funct3;
        is_mop    = (bus.ALUOp == ALUOP_RTYPE) && (bus.Funct7 == F7_MULDIV);
        is_div_op = f3 inside {F3_DIV, F3_DIVU, F3_REM, F3_REMU};
        is_rem    = f3 inside {F3_REM, F3_REMU};
        a_signed  = f3 inside {F3_MULH, F3_MULHSU, F3_DIV, F3_REM};
        b_signed  = f3 inside {F3_MULH, F3_DIV, F3_REM};
        a_neg     = a_signed && bus.src_a[XLEN-1];
        b_neg     = b_signed && bus.src_b[XLEN-1];
        a_mag     = a_neg ? -bus.src_a : bus.src_a;
        b_mag     = b_neg ? -bus.src_b : bus.src_b;
        div_zero  = (bus.src_b == '0);
        div_ovf   = a_signed && is_div_op && (bus.src_a == MIN_VAL) && (bus.src_b == '1);
        sel_hi    = is_div_op ? is_rem : (f3 inside {F3_MULH, F3_MULHSU, F3_MULHU});
        neg_res   = is_rem ? a_neg : (a_neg ^ b_neg);
        if (div_zero) special_res = is_rem ? bus.src_a : '1;
        else          special_res = is_rem ? '0 : MIN_VAL;
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        result_d  = result_q;
        illegal_d = illegal_q;
        dp_load   = 1'b0;
        dp_step   = 1'b0;
        if (bus.flush) begin
            state_d = IDLE;
            cnt_d   = '0;
        end else begin
            case (state_q)
                IDLE: if (bus.in_valid) begin
                    if (!is_mop) begin
                        state_d   = DONE;
                        result_d  = '0;
                        illegal_d = 1'b1;
                    end else if (is_div_op && (div_zero || div_ovf)) begin
                        state_d   = DONE;
                        result_d  = special_res;
                        illegal_d = 1'b0;
                    end else begin
                        state_d   = is_div_op ? DIV : MUL;
                        cnt_d     = CNT_INIT;
                        illegal_d = 1'b0;
                        dp_load   = 1'b1;
                    end
                end
                MUL, DIV: begin
                    dp_step = 1'b1;
                    if (cnt_q == '0) begin
                        state_d  = DONE;
                        result_d = dp_res;
                    end else begin
                        cnt_d = cnt_q - CNT_W'(1);
                    end
                end
                DONE: if (bus.out_ready) state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            result_q  <= '0;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            result_q  <= result_d;
            illegal_q <= illegal_d;
        end
    end

    muldiv_datapath #(.XLEN(XLEN)) u_datapath (
        .clk    (clk),
        .reset  (reset),
        .load   (dp_load),
        .step   (dp_step),
        .is_div (is_div_op),
        .neg    (neg_res),
        .sel_hi (sel_hi),
        .a_mag  (a_mag),
        .b_mag  (b_mag),
        .res    (dp_res)
    );

    assign bus.in_ready  = (state_q == IDLE) && !bus.flush;
    assign bus.out_valid = (state_q == DONE);
    assign bus.busy      = (state_q != IDLE);
    assign bus.result    = result_q;
    assign bus.illegal   = illegal_q;
endmodule

// File: tb/tb_alu_muldiv_controller.sv
// tb/tb_alu_muldiv_controller.sv - vector table, corner sequences and random ops against an arithmetic model
module tb_alu_muldiv_controller;
    import alu_muldiv_pkg::*;

    localparam int XLEN = 32;

    logic clk = 1'b0;
    logic reset;
    alu_muldiv_if #(.XLEN(XLEN)) bus ();

    alu_muldiv_controller #(.XLEN(XLEN)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [1:0]  op;
        logic [6:0]  f7;
        logic [2:0]  f3;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] res;
        logic        ill;
        int          lat;
    } vec_t;

    vec_t vecs[16];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] ref_model(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb, ua, ub;
        logic [63:0] r;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = longint'({32'h0, a});
        ub = longint'({32'h0, b});
        case (f3)
            3'd0: begin r = sa * sb; return r[31:0]; end
            3'd1: begin r = sa * sb; return r[63:32]; end
            3'd2: begin r = sa * ub; return r[63:32]; end
            3'd3: begin r = ua * ub; return r[63:32]; end
            3'd4: begin
                if (b == 0) return 32'hFFFF_FFFF;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
                r = sa / sb; return r[31:0];
            end
            3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
            3'd6: begin
                if (b == 0) return a;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h0;
                r = sa % sb; return r[31:0];
            end
            default: return (b == 0) ? a : a % b;
        endcase
    endfunction

    task automatic start_op(input logic [1:0] op, input logic [6:0] f7, input logic [2:0] f3,
                            input logic [31:0] a, input logic [31:0] b);
        int waited = 0;
        while (!bus.in_ready && waited < 50) begin tick(); waited++; end
        bus.in_valid = 1'b1;
        bus.ALUOp    = op;
        bus.Funct7   = f7;
        bus.Funct3   = f3;
        bus.src_a    = a;
        bus.src_b    = b;
        tick();
        bus.in_valid = 1'b0;
        bus.src_a    = $urandom;
        bus.src_b    = $urandom;
        bus.Funct3   = 3'($urandom);
    endtask

    task automatic run_op(input string name, input logic [1:0] op, input logic [6:0] f7, input logic [2:0] f3,
                          input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] exp_res, input logic exp_ill, input int exp_lat);
        int   lat;
        logic rdy_seen;
        start_op(op, f7, f3, a, b);
        lat = 1;
        rdy_seen = 1'b0;
        while (!bus.out_valid && lat < 100) begin
            if (bus.in_ready) rdy_seen = 1'b1;
            tick();
            lat++;
        end
        if (bus.in_ready) rdy_seen = 1'b1;
        check({name, " latency"}, lat, exp_lat);
        check({name, " result"}, bus.result, exp_res);
        check({name, " illegal"}, bus.illegal, exp_ill);
        check({name, " in_ready while busy"}, rdy_seen, 1'b0);
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
        check({name, " idle after ready"}, bus.busy, 1'b0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic        stable_bad, seen;
        logic [2:0]  f3;
        logic [31:0] a, b;
        int          sel, exp_lat, cnt;

        vecs[0]  = '{ALUOP_RTYPE, F7_MULDIV, F3_MUL,    32'd7,        32'hFFFFFFFD, 32'hFFFFFFEB, 1'b0, 33};
        vecs[1]  = '{ALUOP_RTYPE, F7_MULDIV, F3_MULHU,  32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 1'b0, 33};
        vecs[2]  = '{ALUOP_RTYPE, F7_MULDIV, F3_MULH,   32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 1'b0, 33};
        vecs[3]  = '{ALUOP_RTYPE, F7_MULDIV, F3_MULHSU, 32'hFFFFFFFF, 32'd2,        32'hFFFFFFFF, 1'b0, 33};
        vecs[4]  = '{ALUOP_RTYPE, F7_MULDIV, F3_DIV,    32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, 1'b0, 33};
        vecs[5]  = '{ALUOP_RTYPE, F7_MULDIV, F3_REM,    32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 1'b0, 33};
        vecs[6]  = '{ALUOP_RTYPE, F7_MULDIV, F3_DIVU,   32'd100,      32'd7,        32'd14,       1'b0, 33};
        vecs[7]  = '{ALUOP_RTYPE, F7_MULDIV, F3_REMU,   32'd100,      32'd7,        32'd2,        1'b0, 33};
        vecs[8]  = '{ALUOP_RTYPE, F7_MULDIV, F3_DIV,    32'd5,        32'd0,        32'hFFFFFFFF, 1'b0, 1};
        vecs[9]  = '{ALUOP_RTYPE, F7_MULDIV, F3_REM,    32'd5,        32'd0,        32'd5,        1'b0, 1};
        vecs[10] = '{ALUOP_RTYPE, F7_MULDIV, F3_DIV,    32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1'b0, 1};
        vecs[11] = '{ALUOP_RTYPE, F7_MULDIV, F3_REM,    32'h80000000, 32'hFFFFFFFF, 32'h00000000, 1'b0, 1};
        vecs[12] = '{ALUOP_RTYPE, 7'b0000000, F3_MUL,   32'd3,        32'd4,        32'h00000000, 1'b1, 1};
        vecs[13] = '{2'b00,       F7_MULDIV, F3_DIV,    32'd9,        32'd3,        32'h00000000, 1'b1, 1};
        vecs[14] = '{ALUOP_RTYPE, F7_MULDIV, F3_REMU,   32'hDEADBEEF, 32'd0,        32'hDEADBEEF, 1'b0, 1};
        vecs[15] = '{ALUOP_RTYPE, F7_MULDIV, F3_DIVU,   32'h80000000, 32'hFFFFFFFF, 32'h00000000, 1'b0, 33};

        bus.flush = 1'b0; bus.in_valid = 1'b0; bus.out_ready = 1'b0;
        bus.ALUOp = 2'b00; bus.Funct7 = 7'h00; bus.Funct3 = 3'h0;
        bus.src_a = '0; bus.src_b = '0;
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;

        check("reset in_ready", bus.in_ready, 1'b1);
        check("reset out_valid", bus.out_valid, 1'b0);
        check("reset result", bus.result, 32'h0);
        check("reset illegal", bus.illegal, 1'b0);
        check("reset busy", bus.busy, 1'b0);

        for (int i = 0; i < 16; i++)
            run_op($sformatf("vec%0d", i), vecs[i].op, vecs[i].f7, vecs[i].f3,
                   vecs[i].a, vecs[i].b, vecs[i].res, vecs[i].ill, vecs[i].lat);

        // backpressure: result must hold while out_ready stays low
        start_op(ALUOP_RTYPE, F7_MULDIV, F3_MUL, 32'd123, 32'd456);
        cnt = 0;
        while (!bus.out_valid && cnt < 100) begin tick(); cnt++; end
        check("bp out_valid", bus.out_valid, 1'b1);
        stable_bad = 1'b0;
        repeat (5) begin
            tick();
            if (bus.result !== 32'd56088 || !bus.out_valid || bus.in_ready) stable_bad = 1'b1;
        end
        check("bp hold stable", stable_bad, 1'b0);
        check("bp result", bus.result, 32'd56088);
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
        check("bp release out_valid", bus.out_valid, 1'b0);
        check("bp release in_ready", bus.in_ready, 1'b1);

        // flush in cycle 10 of a divide
        start_op(ALUOP_RTYPE, F7_MULDIV, F3_DIV, 32'd1000, 32'd3);
        repeat (9) tick();
        bus.flush = 1'b1;
        #1 check("flush in_ready low", bus.in_ready, 1'b0);
        tick();
        bus.flush = 1'b0;
        check("flush busy", bus.busy, 1'b0);
        check("flush out_valid", bus.out_valid, 1'b0);
        seen = 1'b0;
        repeat (40) begin tick(); if (bus.out_valid) seen = 1'b1; end
        check("flush no result", seen, 1'b0);
        run_op("after flush", ALUOP_RTYPE, F7_MULDIV, F3_MUL, 32'd1234, 32'd5678, 32'd7006652, 1'b0, 33);

        // request presented together with flush is dropped
        bus.flush = 1'b1; bus.in_valid = 1'b1;
        bus.ALUOp = ALUOP_RTYPE; bus.Funct7 = F7_MULDIV; bus.Funct3 = F3_MUL;
        #1 check("flush idle in_ready", bus.in_ready, 1'b0);
        tick();
        bus.flush = 1'b0; bus.in_valid = 1'b0;
        check("flush idle busy", bus.busy, 1'b0);
        tick();
        check("flush idle out_valid", bus.out_valid, 1'b0);

        // reset in the middle of a multiply
        start_op(ALUOP_RTYPE, F7_MULDIV, F3_MUL, 32'd99, 32'd77);
        repeat (5) tick();
        #2 reset = 1'b1;
        #1;
        check("midreset in_ready", bus.in_ready, 1'b1);
        check("midreset out_valid", bus.out_valid, 1'b0);
        check("midreset result", bus.result, 32'h0);
        check("midreset illegal", bus.illegal, 1'b0);
        check("midreset busy", bus.busy, 1'b0);
        tick();
        reset = 1'b0;
        run_op("after reset", ALUOP_RTYPE, F7_MULDIV, F3_MUL, 32'd99, 32'd77, 32'd7623, 1'b0, 33);

        for (int i = 0; i < 40; i++) begin
            f3  = 3'($urandom_range(0, 7));
            sel = $urandom_range(0, 9);
            a   = $urandom;
            b   = $urandom;
            if (sel == 0) b = 32'h0;
            else if (sel == 1) begin a = 32'h80000000; b = 32'hFFFFFFFF; end
            else if (sel == 2) b = 32'($urandom_range(1, 15));
            exp_lat = (f3[2] && (b == 0 || ((f3 == F3_DIV || f3 == F3_REM) &&
                       a == 32'h80000000 && b == 32'hFFFFFFFF))) ? 1 : 33;
            run_op($sformatf("rand%0d f3=%0d a=%h b=%h", i, f3, a, b), ALUOP_RTYPE, F7_MULDIV,
                   f3, a, b, ref_model(f3, a, b), 1'b0, exp_lat);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
